text_layer: RTL and testbench

TEXT_LAYER -- requirements
Module: text_layer

---
 rtl/text_layer_pkg.sv | 38 +++
 rtl/text_layer_blink.sv | 42 ++++
 rtl/text_layer.sv | 138 +++++++++++++
 tb/tb_text_layer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/text_layer_pkg.sv
// ============================================================================
// text_layer_pkg : shared video constants, tram word layout and cell helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package text_layer_pkg;

    localparam int CHAR_W_40 = 16;
    localparam int CHAR_W_80 = 8;
    localparam int COLS_40   = 40;
    localparam int COLS_80   = 80;

    typedef enum logic {
        MODE_40 = 1'b0,
        MODE_80 = 1'b1
    } col_mode_t;

    typedef struct packed {
        logic [7:0] color;
        logic [7:0] code;
    } tram_word_t;

    // True on the first pixel of a character cell.
    function automatic logic cell_start(input col_mode_t mode, input logic [3:0] h);
        logic [3:0] mask;
        mask = (mode == MODE_80) ? 4'(CHAR_W_80 - 1) : 4'(CHAR_W_40 - 1);
        return (h & mask) == 4'd0;
    endfunction

    // Column within the 8-bit glyph row; 40-col doubles each pixel.
    function automatic logic [2:0] pix_sel(input col_mode_t mode, input logic [3:0] h);
        return (mode == MODE_80) ? h[2:0] : h[3:1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/text_layer_blink.sv
// ============================================================================
// text_blink : cursor blink phase, toggles every BLINK_DIV vblank rising edges
// Rev 1.0
// ============================================================================
`default_nettype none

module text_blink #(
    parameter int BLINK_DIV = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic vblank,
    output logic phase
);

    logic       r_vblank_d;
    logic [7:0] r_cnt;
    logic       r_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vblank_d <= 1'b0;
            r_cnt      <= 8'd0;
            r_phase    <= 1'b0;
        end else begin
            r_vblank_d <= vblank;
            if (vblank && !r_vblank_d) begin
                if (r_cnt == 8'(BLINK_DIV - 1)) begin
                    r_cnt   <= 8'd0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign phase = r_phase;

endmodule

`default_nettype wire

// File: rtl/text_layer.sv
// ============================================================================
// text_layer : character-cell text renderer, 40/80 columns, blinking cursor
// Rev 1.0
// ============================================================================
`default_nettype none

module text_layer
    import text_layer_pkg::*;
#(
    parameter int CHAR_H    = 8,
    parameter int TRAM_AW   = 11,
    parameter int BLINK_DIV = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [9:0]                     hpos,
    input  logic                           blank,
    input  logic                           vblank,
    input  logic                           vnext,
    input  logic                           reg_mode80,
    input  logic [TRAM_AW-1:0]             reg_row_start,
    input  logic [$clog2(CHAR_H)-1:0]      reg_fine_y,
    input  logic                           reg_cursor_en,
    input  logic [TRAM_AW-1:0]             reg_cursor_addr,
    output logic [TRAM_AW-1:0]             tram_addr,
    input  logic [15:0]                    tram_rddata,
    output logic [8+$clog2(CHAR_H)-1:0]    chram_addr,
    input  logic [7:0]                     chram_rddata,
    output logic [3:0]                     colidx,
    output logic                           de
);

    localparam int LINE_W = $clog2(CHAR_H);

    col_mode_t          r_mode;
    logic [TRAM_AW-1:0] r_row_addr;
    logic [LINE_W-1:0]  r_line;
    logic [TRAM_AW-1:0] r_char_addr;
    logic               r_blank_d;

    logic [2:0]         r_s1_sel;
    logic               r_s1_act;
    logic [2:0]         r_s2_sel;
    logic               r_s2_act;
    logic [7:0]         r_s2_color;
    logic               r_s2_swap;
    logic [3:0]         r_colidx;
    logic               r_de;

    logic [TRAM_AW-1:0] w_char_next;
    tram_word_t         w_word;
    logic               w_phase;
    logic               w_pix;
    logic [3:0]         w_fg;
    logic [3:0]         w_bg;
    logic               w_unused_hpos;

    assign w_unused_hpos = ^hpos[9:4];
    assign w_word        = tram_word_t'(tram_rddata);

    text_blink #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk    (clk),
        .reset  (reset),
        .vblank (vblank),
        .phase  (w_phase)
    );

    // Frame-level state: registers are sampled only while vblank is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode     <= MODE_40;
            r_row_addr <= '0;
            r_line     <= '0;
        end else if (vblank) begin
            r_mode     <= col_mode_t'(reg_mode80);
            r_row_addr <= reg_row_start;
            r_line     <= reg_fine_y;
        end else if (vnext) begin
            if (r_line == LINE_W'(CHAR_H - 1)) begin
                r_line     <= '0;
                r_row_addr <= r_row_addr + ((r_mode == MODE_80) ? TRAM_AW'(COLS_80)
                                                                : TRAM_AW'(COLS_40));
            end else begin
                r_line <= r_line + LINE_W'(1);
            end
        end
    end

    always_comb begin
        w_char_next = r_char_addr;
        if (r_blank_d && !blank) begin
            w_char_next = r_row_addr;
        end else if (!blank && cell_start(r_mode, hpos[3:0])) begin
            w_char_next = r_char_addr + TRAM_AW'(1);
        end
    end

    // Addresses are the d-values so RAM data lines up with the next stage.
    assign tram_addr  = reset ? w_char_next : '0;
    assign chram_addr = reset ? {w_word.code, r_line} : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_char_addr <= '0;
            r_blank_d   <= 1'b0;
            r_s1_sel    <= 3'd0;
            r_s1_act    <= 1'b0;
            r_s2_sel    <= 3'd0;
            r_s2_act    <= 1'b0;
            r_s2_color  <= 8'd0;
            r_s2_swap   <= 1'b0;
            r_colidx    <= 4'd0;
            r_de        <= 1'b0;
        end else begin
            r_char_addr <= w_char_next;
            r_blank_d   <= blank;
            r_s1_sel    <= pix_sel(r_mode, hpos[3:0]);
            r_s1_act    <= !blank;
            r_s2_sel    <= r_s1_sel;
            r_s2_act    <= r_s1_act;
            r_s2_color  <= w_word.color;
            r_s2_swap   <= reg_cursor_en && w_phase && (r_char_addr == reg_cursor_addr);
            r_colidx    <= r_s2_act ? ((w_pix ^ r_s2_swap) ? w_fg : w_bg) : 4'd0;
            r_de        <= r_s2_act;
        end
    end

    assign w_pix  = chram_rddata[3'd7 - r_s2_sel];
    assign w_fg   = r_s2_color[7:4];
    assign w_bg   = r_s2_color[3:0];
    assign colidx = r_colidx;
    assign de     = r_de;

endmodule

`default_nettype wire

// File: tb/tb_text_layer.sv
// ============================================================================
// tb_text_layer : directed self-checking bench for text_layer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_text_layer;

    logic        clk;
    logic        reset;
    logic [9:0]  hpos;
    logic        blank;
    logic        vblank;
    logic        vnext;
    logic        reg_mode80;
    logic [10:0] reg_row_start;
    logic [3:0]  reg_fine_y;
    logic        reg_cursor_en;
    logic [10:0] reg_cursor_addr;
    logic [10:0] tram_addr;
    logic [15:0] tram_rddata;
    logic [11:0] chram_addr;
    logic [7:0]  chram_rddata;
    logic [3:0]  colidx;
    logic        de;

    logic [15:0] tram  [0:2047];
    logic [7:0]  chram [0:4095];

    logic [3:0]  cap_col [0:255];
    logic        cap_de  [0:255];
    logic        pre_de;
    logic [10:0] first_addr;
    logic [10:0] addr8;
    logic [11:0] first_line;

    int n_pass;
    int n_total;

    text_layer #(
        .CHAR_H    (16),
        .TRAM_AW   (11),
        .BLINK_DIV (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .hpos            (hpos),
        .blank           (blank),
        .vblank          (vblank),
        .vnext           (vnext),
        .reg_mode80      (reg_mode80),
        .reg_row_start   (reg_row_start),
        .reg_fine_y      (reg_fine_y),
        .reg_cursor_en   (reg_cursor_en),
        .reg_cursor_addr (reg_cursor_addr),
        .tram_addr       (tram_addr),
        .tram_rddata     (tram_rddata),
        .chram_addr      (chram_addr),
        .chram_rddata    (chram_rddata),
        .colidx          (colidx),
        .de              (de)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        tram_rddata  <= tram[tram_addr];
        chram_rddata <= chram[chram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_vblank();
        @(negedge clk);
        blank  = 1'b1;
        vblank = 1'b1;
        repeat (3) @(negedge clk);
        vblank = 1'b0;
    endtask

    task automatic do_vnext();
        @(negedge clk);
        blank = 1'b1;
        vnext = 1'b1;
        @(negedge clk);
        vnext = 1'b0;
    endtask

    // Sample taken at iteration j shows the pixel driven at iteration j-3.
    task automatic run_line(input int npix);
        for (int j = 0; j < npix + 6; j++) begin
            @(negedge clk);
            if (j == 2) pre_de = de;
            if (j >= 3) begin
                cap_col[j-3] = colidx;
                cap_de[j-3]  = de;
            end
            blank = (j >= npix);
            hpos  = (j < npix) ? 10'(j) : 10'd0;
            #1;
            if (j == 0) first_addr = tram_addr;
            if (j == 1) first_line = chram_addr;
            if (j == 8) addr8 = tram_addr;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sw;
        n_pass = 0;
        n_total = 0;
        for (int i = 0; i < 2048; i++) tram[i] = 16'h0000;
        for (int i = 0; i < 4096; i++) chram[i] = 8'h00;
        tram[0]          = 16'h1F41;
        chram[12'h410]   = 8'h18;
        tram[2]          = 16'h5A00;
        chram[12'h000]   = 8'hF0;
        tram[11'h7F0]    = 16'h3C41;
        chram[12'h41F]   = 8'h81;
        tram[11'h7F1]    = 16'h7200;

        reset = 1'b0; hpos = 10'd0; blank = 1'b1; vblank = 1'b0; vnext = 1'b0;
        reg_mode80 = 1'b0; reg_row_start = 11'd0; reg_fine_y = 4'd0;
        reg_cursor_en = 1'b1; reg_cursor_addr = 11'h002;

        repeat (3) @(negedge clk);
        check("rst_colidx", 32'(colidx), 32'h0);
        check("rst_de", 32'(de), 32'h0);
        check("rst_tram_addr", 32'(tram_addr), 32'h0);
        check("rst_chram_addr", 32'(chram_addr), 32'h0);
        reset = 1'b1;

        // Cursor blink: frames counted by vblank edges since reset
        for (int f = 1; f <= 5; f++) begin
            do_vblank();
            run_line(48);
            sw = (f == 2) || (f == 3);
            check($sformatf("cur_f%0d_px0", f), 32'(cap_col[0]), 32'hF);
            check($sformatf("cur_f%0d_px32", f), 32'(cap_col[32]), sw ? 32'hA : 32'h5);
            check($sformatf("cur_f%0d_px40", f), 32'(cap_col[40]), sw ? 32'h5 : 32'hA);
        end
        reg_cursor_en = 1'b0;

        // 40-col 'A' glyph; mode80 change after vblank must not apply
        reg_mode80 = 1'b0;
        do_vblank();
        reg_mode80 = 1'b1;
        run_line(20);
        reg_mode80 = 1'b0;
        check("a_pre_de", 32'(pre_de), 32'h0);
        check("a_de_px0", 32'(cap_de[0]), 32'h1);
        check("a_first_addr", 32'(first_addr), 32'h0);
        check("a_chram_addr", 32'(first_line), 32'h410);
        for (int p = 0; p < 16; p++)
            check($sformatf("a_px%0d", p), 32'(cap_col[p]),
                  ((p >= 6) && (p <= 9)) ? 32'h1 : 32'hF);
        check("a_blank_colidx", 32'(cap_col[20]), 32'h0);
        check("a_blank_de", 32'(cap_de[20]), 32'h0);

        // CHAR_H=16 with fine_y=5: 11 lines before the row advances
        reg_row_start = 11'h100;
        reg_fine_y    = 4'd5;
        do_vblank();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) do_vnext();
            run_line(4);
            check($sformatf("fy_row_l%0d", k), 32'(first_addr), (k < 11) ? 32'h100 : 32'h128);
            check($sformatf("fy_line_l%0d", k), 32'(first_line[3:0]),
                  (k < 11) ? 32'(5 + k) : 32'h0);
        end

        // 80-col, row advance wraps modulo 2^11
        reg_mode80    = 1'b1;
        reg_row_start = 11'h7F0;
        reg_fine_y    = 4'd15;
        do_vblank();
        run_line(16);
        check("m80_first_addr", 32'(first_addr), 32'h7F0);
        check("m80_addr_px8", 32'(addr8), 32'h7F1);
        check("m80_px0", 32'(cap_col[0]), 32'h3);
        check("m80_px1", 32'(cap_col[1]), 32'hC);
        check("m80_px7", 32'(cap_col[7]), 32'h3);
        check("m80_px8", 32'(cap_col[8]), 32'h2);
        do_vnext();
        run_line(4);
        check("m80_wrap_addr", 32'(first_addr), 32'h040);
        check("m80_wrap_chram", 32'(first_line), 32'h000);

        // Asynchronous reset in the middle of a visible line
        reg_mode80    = 1'b0;
        reg_row_start = 11'd0;
        reg_fine_y    = 4'd0;
        do_vblank();
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            blank = 1'b0;
            hpos  = 10'(j);
        end
        #2;
        check("mid_colidx_pre", 32'(colidx), 32'h1);
        check("mid_de_pre", 32'(de), 32'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_colidx", 32'(colidx), 32'h0);
        check("mid_rst_de", 32'(de), 32'h0);
        check("mid_rst_tram", 32'(tram_addr), 32'h0);
        check("mid_rst_chram", 32'(chram_addr), 32'h0);
        @(negedge clk);
        blank = 1'b1;
        hpos  = 10'd0;
        @(negedge clk);
        reset = 1'b1;
        do_vblank();
        run_line(16);
        check("rec_pre_de", 32'(pre_de), 32'h0);
        check("rec_de_px0", 32'(cap_de[0]), 32'h1);
        check("rec_px0", 32'(cap_col[0]), 32'hF);
        check("rec_px6", 32'(cap_col[6]), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
